pixel_fb_writer: RTL and testbench
==================================

// Module: pixel_fb_writer
// PURPOSE
//  Downstream stage of the rasterisers (line/filled-triangle). Takes their (x,y) pixel stream
//  through a valid/ready handshake and buffers it in a small FIFO. Clips off-screen pixels,
//  drops consecutive duplicates and issues single-cycle framebuffer writes (linear address).
//  Also owns the framebuffer clear sweep that runs between frames.
// PARAMETERS
//  H_RES       640   visible width in pixels
//  V_RES       480   visible height in pixels
//  COLOR_W     8     colour/data width per pixel
//  FIFO_DEPTH  8     input FIFO entries (power of 2)
//  ADDR_W      19    framebuffer address width (>= clog2(H_RES*V_RES))
// PORTS
//  clk          in   1        single clock, all logic on posedge
//  reset_n      in   1        synchronous, active-low reset
//  pix_x        in   10       pixel x from rasteriser
//  pix_y        in   9        pixel y from rasteriser
//  pix_color    in   COLOR_W  pixel colour
//  pix_valid    in   1        pixel present this cycle
//  pix_ready    out  1        accept; transfer when pix_valid & pix_ready
//  clear_req    in   1        one-cycle pulse: clear framebuffer
//  clear_color  in   COLOR_W  fill colour, latched with clear_req
//  busy         out  1        high while draining/clearing
//  fb_we        out  1        framebuffer write strobe
//  fb_addr      out  ADDR_W   framebuffer address = y*H_RES + x
//  fb_data      out  COLOR_W  write data
//  fb_wait      in   1        memory stall; write completes only in a cycle with fb_wait=0
//  drop_cnt     out  16       count of clipped pixels, saturating at 0xFFFF
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): FIFO empty, state RUN, fb_we=0, fb_addr=0, fb_data=0, busy=0,
//   drop_cnt=0, last-pixel tag invalid. Applies mid-write/mid-clear too: pending data discarded.
//  pix_ready = !fifo_full & (state==RUN), registered from the flags; simultaneous push and pop allowed.
//  Pop when state RUN, FIFO non-empty, output register free (fb_we=0 or fb_wait=0).
//  Popped pixel handling, evaluated in this order:
//   1. x>=H_RES or y>=V_RES: discard, drop_cnt+1 (saturating).
//   2. (x,y,color)==last written and tag valid: discard silently.
//   3. Otherwise: register fb_we=1, fb_addr=(y<<9)+(y<<7)+x (H_RES=640), fb_data=color, update tag.
//  Latency: pixel accepted in cycle N -> fb_we high in cycle N+2 at the earliest.
//  While fb_we=1 & fb_wait=1: fb_we/fb_addr/fb_data held stable, no pop.
//  States: RUN -> DRAIN on clear_req (clear_color latched) -> CLEAR once FIFO empty and no
//   pending write -> RUN after the write to addr H_RES*V_RES-1 completes.
//  DRAIN: queued pixels still written normally; pix_ready=0.
//  CLEAR: fb_we=1, fb_addr counts 0..H_RES*V_RES-1, one per completed write, fb_data=latched colour.
//  CLEAR exit: tag invalidated at end of CLEAR.
//  busy=1 in DRAIN and CLEAR; busy falls the cycle after the last clear write completes.
//  clear_req in DRAIN/CLEAR is ignored.
//  clear_req coinciding with a push: the push is accepted (ready was already high), then drained.
// STRUCTURE
//  fb_pkg: H_RES, V_RES, ADDR_W, COLOR_W defaults; state encoding RUN/DRAIN/CLEAR.
//  Sub-module pix_fifo: synchronous FIFO, width 10+9+COLOR_W, depth FIFO_DEPTH, full/empty flags.
//  Top: FSM, clip/dedup, shift-add address, output register, clear counter, drop counter.
// TESTING
//  1. Hold reset_n=0 for 2 clk with pix_valid=1 -> fb_we=0, busy=0, drop_cnt=0;
//     pix_ready=1 the cycle after release.
//  2. (10,20,0x3C) accepted in cycle N -> fb_we=1 in N+2, fb_addr=12810, fb_data=0x3C, one cycle.
//  3. (640,0) then (0,480) -> no fb_we, drop_cnt=2. Then (639,479) -> fb_addr=307199.
//  4. (5,5,0x11) x3 back-to-back, then (6,5,0x11) -> exactly two writes: addr 3205, then 3206.
//  5. fb_wait=1 and push 12 pixels -> pix_ready low after 9 accepted (8 FIFO + 1 output reg),
//     outputs stable. Release fb_wait -> all 9 written in order, then ready=1.
//  6. 2 pixels queued, clear_req with clear_color=0x00 -> both written, then 307200 writes to
//     addr 0..307199 data 0x00. Then busy=0 and pix_ready=1; the old pixel is rewritten after
//     the clear (tag reset).

Source files
------------

// File: rtl/fb_pkg.sv
// Shared definitions for the pixel framebuffer writer: default geometry,
// pixel field widths, controller state encoding and the row-base helper.
package fb_pkg;

    // Default screen geometry and datapath widths
    localparam int H_RES_DEF      = 640;
    localparam int V_RES_DEF      = 480;
    localparam int COLOR_W_DEF    = 8;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int ADDR_W_DEF     = 19;

    // Coordinate widths coming from the rasterisers
    localparam int X_W = 10;
    localparam int Y_W = 9;

    // Controller states
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } fb_state_e;

    // Linear offset of the first pixel of row y. For the 640-wide screen this is
    // y*512 + y*128, which needs only an adder; other widths use a plain multiply.
    function automatic logic [31:0] row_base(input logic [Y_W-1:0] y,
                                             input int unsigned h_res);
        logic [31:0] y_ext;
        y_ext = {{(32-Y_W){1'b0}}, y};
        if (h_res == 32'd640) begin
            return (y_ext << 9) + (y_ext << 7);
        end
        return y_ext * h_res;
    endfunction

endpackage

// File: rtl/pix_fifo.sv
// Small synchronous FIFO holding packed {x, y, colour} pixels between the
// rasteriser handshake and the framebuffer write stage. Head entry is visible
// combinationally on rd_data so a pop can be consumed in the same cycle.
module pix_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          wr_en, rd_en;

    // Guard the pointers so an overflow or underflow request can never corrupt state
    always_comb begin
        wr_en    = push && !full;
        rd_en    = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end

    // Pointer and occupancy registers; reset empties the queue
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/pixel_fb_writer.sv
// Framebuffer write stage behind the line/triangle rasterisers. Buffers the
// incoming pixel stream, clips off-screen pixels (counting them), suppresses
// back-to-back repeats of the last written pixel and issues one framebuffer
// write per completed memory cycle. Between frames it sweeps the whole buffer
// with a latched fill colour.
module pixel_fb_writer
    import fb_pkg::*;
#(
    parameter int H_RES      = H_RES_DEF,
    parameter int V_RES      = V_RES_DEF,
    parameter int COLOR_W    = COLOR_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [9:0]          pix_x,
    input  logic [8:0]          pix_y,
    input  logic [COLOR_W-1:0]  pix_color,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic                clear_req,
    input  logic [COLOR_W-1:0]  clear_color,
    output logic                busy,
    output logic                fb_we,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic [COLOR_W-1:0]  fb_data,
    input  logic                fb_wait,
    output logic [15:0]         drop_cnt
);

    localparam int PIX_W = X_W + Y_W + COLOR_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [X_W:0]      X_LIM     = (X_W+1)'(H_RES);
    localparam logic [Y_W:0]      Y_LIM     = (Y_W+1)'(V_RES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    // Registered state
    fb_state_e            state_q,     state_d;
    logic                 fb_we_q,     fb_we_d;
    logic [ADDR_W-1:0]    fb_addr_q,   fb_addr_d;
    logic [COLOR_W-1:0]   fb_data_q,   fb_data_d;
    logic [COLOR_W-1:0]   clr_color_q, clr_color_d;
    logic [15:0]          drop_q,      drop_d;
    logic [PIX_W-1:0]     tag_q,       tag_d;
    logic                 tag_v_q,     tag_v_d;
    logic                 busy_q,      busy_d;
    logic                 ready_q,     ready_d;

    // FIFO interface
    logic [PIX_W-1:0]     fifo_wr_data;
    logic [PIX_W-1:0]     fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic                 push;
    logic                 pop;
    logic                 out_free;
    logic [CNT_W-1:0]     occ_next;

    // Fields of the pixel at the FIFO head
    logic [X_W-1:0]       head_x;
    logic [Y_W-1:0]       head_y;
    logic [COLOR_W-1:0]   head_c;
    logic                 head_clipped;
    logic                 head_dup;
    logic [ADDR_W-1:0]    head_addr;

    assign fifo_wr_data = {pix_x, pix_y, pix_color};

    pix_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wr_data (fifo_wr_data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Handshake and pop decision: the output register is free when idle or
    // when its current write is completing this cycle
    always_comb begin
        out_free = !fb_we_q || !fb_wait;
        push     = pix_valid && ready_q && !fifo_full;
        pop      = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !fifo_empty && out_free;
        occ_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
    end

    // Classify the head pixel: off-screen, repeat of the last write, and its linear address
    always_comb begin
        head_x       = fifo_rd_data[PIX_W-1 -: X_W];
        head_y       = fifo_rd_data[COLOR_W +: Y_W];
        head_c       = fifo_rd_data[COLOR_W-1:0];
        head_clipped = ({1'b0, head_x} >= X_LIM) || ({1'b0, head_y} >= Y_LIM);
        head_dup     = tag_v_q && (fifo_rd_data == tag_q);
        head_addr    = ADDR_W'(row_base(head_y, H_RES) + {{(32-X_W){1'b0}}, head_x});
    end

    // Next-state logic: controller states, output register, clear sweep, drop counter, tag
    always_comb begin
        state_d     = state_q;
        fb_we_d     = fb_we_q;
        fb_addr_d   = fb_addr_q;
        fb_data_d   = fb_data_q;
        clr_color_d = clr_color_q;
        drop_d      = drop_q;
        tag_d       = tag_q;
        tag_v_d     = tag_v_q;

        // A write that is not stalled retires at this edge
        if (fb_we_q && !fb_wait) begin
            fb_we_d = 1'b0;
        end

        case (state_q)
            ST_RUN: begin
                if (clear_req) begin
                    state_d     = ST_DRAIN;
                    clr_color_d = clear_color;
                end
            end
            ST_DRAIN: begin
                // Start the sweep once nothing queued and nothing left in the output register
                if (fifo_empty && out_free) begin
                    state_d   = ST_CLEAR;
                    fb_we_d   = 1'b1;
                    fb_addr_d = '0;
                    fb_data_d = clr_color_q;
                end
            end
            ST_CLEAR: begin
                // fb_addr doubles as the sweep counter; it advances only on completed writes
                fb_we_d = 1'b1;
                if (!fb_wait) begin
                    if (fb_addr_q == LAST_ADDR) begin
                        state_d = ST_RUN;
                        fb_we_d = 1'b0;
                        tag_v_d = 1'b0;
                    end else begin
                        fb_addr_d = fb_addr_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (pop) begin
            if (head_clipped) begin
                if (drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
            end else if (!head_dup) begin
                fb_we_d   = 1'b1;
                fb_addr_d = head_addr;
                fb_data_d = head_c;
                tag_d     = fifo_rd_data;
                tag_v_d   = 1'b1;
            end
        end
    end

    // Status outputs are registered from the upcoming state and occupancy so
    // ready drops in time to protect the FIFO and busy tracks the state exactly
    always_comb begin
        busy_d  = (state_d != ST_RUN);
        ready_d = (state_d == ST_RUN) && (occ_next < DEPTH_C);
    end

    // All registers; reset discards any in-flight write or sweep
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
            clr_color_q <= '0;
            drop_q      <= '0;
            tag_q       <= '0;
            tag_v_q     <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fb_we_q     <= fb_we_d;
            fb_addr_q   <= fb_addr_d;
            fb_data_q   <= fb_data_d;
            clr_color_q <= clr_color_d;
            drop_q      <= drop_d;
            tag_q       <= tag_d;
            tag_v_q     <= tag_v_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    assign pix_ready = ready_q;
    assign busy      = busy_q;
    assign fb_we     = fb_we_q;
    assign fb_addr   = fb_addr_q;
    assign fb_data   = fb_data_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Self-checking bench for pixel_fb_writer. A reduced screen height keeps the
// clear sweep short; the width stays 640 so the shift-add address path is used.
module tb_pixel_fb_writer;

    localparam int H     = 640;
    localparam int V     = 32;
    localparam int CW    = 8;
    localparam int AW    = 19;
    localparam int DEPTH = 8;
    localparam int NPIX  = H * V;

    typedef logic [AW+CW-1:0] wr_t;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [9:0]     pix_x = '0;
    logic [8:0]     pix_y = '0;
    logic [CW-1:0]  pix_color = '0;
    logic           pix_valid = 1'b0;
    logic           pix_ready;
    logic           clear_req = 1'b0;
    logic [CW-1:0]  clear_color = '0;
    logic           busy;
    logic           fb_we;
    logic [AW-1:0]  fb_addr;
    logic [CW-1:0]  fb_data;
    logic           fb_wait = 1'b0;
    logic [15:0]    drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int wait_mode = 0;

    // Reference model state
    wr_t  exp_q[$];
    wr_t  act_q[$];
    int   exp_total = 0;
    int   wr_total = 0;
    int   clear_end = 0;
    int   m_drop = 0;
    logic [26:0] m_tag = '0;
    bit   m_tag_v = 0;

    always #5 clk = ~clk;

    pixel_fb_writer #(
        .H_RES      (H),
        .V_RES      (V),
        .COLOR_W    (CW),
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (AW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_color   (pix_color),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .busy        (busy),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .fb_wait     (fb_wait),
        .drop_cnt    (drop_cnt)
    );

    // Memory stall driver: 0 = never, 1 = always, otherwise random
    always @(negedge clk) begin
        #1;
        case (wait_mode)
            0:       fb_wait = 1'b0;
            1:       fb_wait = 1'b1;
            default: fb_wait = ($urandom_range(3) == 0);
        endcase
    end

    // Behavioural model fed by accepted pixels and accepted clears; also records completed writes
    always @(posedge clk) begin
        bit clr_ok;
        if (!reset_n) begin
            exp_q.delete();
            act_q.delete();
            exp_total = 0;
            wr_total  = 0;
            clear_end = 0;
            m_drop    = 0;
            m_tag_v   = 0;
        end else begin
            clr_ok = (wr_total >= clear_end);
            if (pix_valid && pix_ready) begin
                if (int'(pix_x) >= H || int'(pix_y) >= V) begin
                    if (m_drop < 65535) m_drop++;
                end else if (!(m_tag_v && m_tag == {pix_x, pix_y, pix_color})) begin
                    exp_q.push_back({AW'(int'(pix_y) * H + int'(pix_x)), pix_color});
                    exp_total++;
                    m_tag   = {pix_x, pix_y, pix_color};
                    m_tag_v = 1;
                end
            end
            if (clear_req && clr_ok) begin
                for (int a = 0; a < NPIX; a++) exp_q.push_back({AW'(a), clear_color});
                exp_total += NPIX;
                clear_end = exp_total;
                m_tag_v   = 0;
            end
            if (fb_we && !fb_wait) begin
                act_q.push_back({fb_addr, fb_data});
                wr_total++;
            end
        end
    end

    // Present one pixel (called at a negedge) and return at the negedge after it is accepted
    task automatic push_pix(input int x, input int y, input int c);
        bit rdy;
        pix_x     = 10'(x);
        pix_y     = 9'(y);
        pix_color = CW'(c);
        pix_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            rdy = pix_ready;
            @(negedge clk);
            if (rdy) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL push_timeout: pix_ready=%0b for 100 cycles, required 1", pix_ready);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        pix_valid = 1'b1;
        pix_x = 10'd1; pix_y = 9'd1; pix_color = 8'h01;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (fb_we !== 1'b0)   begin n_bad++; $display("FAIL reset_we: got %b required 0", fb_we); end
        n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_drop: got %0d required 0", drop_cnt); end
        n_cmp++; if (fb_addr !== '0 || fb_data !== '0) begin n_bad++; $display("FAIL reset_addr_data: got %0d/%h required 0/00", fb_addr, fb_data); end
        pix_valid = 1'b0;
        reset_n   = 1'b1;
        @(negedge clk);
        n_cmp++; if (pix_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b required 1", pix_ready); end
        $display("reset: done, compared %0d so far", n_cmp);
    endtask

    task automatic test_latency();
        n_cmp++; if (pix_ready !== 1'b1) begin n_bad++; $display("FAIL lat_ready: got %b required 1", pix_ready); end
        pix_x = 10'd10; pix_y = 9'd20; pix_color = 8'h3C; pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        n_cmp++; if (fb_we !== 1'b0) begin n_bad++; $display("FAIL lat_n1: fb_we=%b required 0", fb_we); end
        @(negedge clk);
        n_cmp++;
        if (fb_we !== 1'b1 || fb_addr !== 19'd12810 || fb_data !== 8'h3C) begin
            n_bad++; $display("FAIL lat_n2: we/addr/data=%b/%0d/%h required 1/12810/3c", fb_we, fb_addr, fb_data);
        end
        @(negedge clk);
        n_cmp++; if (fb_we !== 1'b0) begin n_bad++; $display("FAIL lat_n3: fb_we=%b required 0", fb_we); end
        $display("latency: write of (10,20) seen at addr %0d", fb_addr);
    endtask

    task automatic test_clip();
        int w0;
        w0 = wr_total;
        push_pix(H, 0, 8'h21);
        push_pix(0, V, 8'h22);
        pix_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (drop_cnt !== 16'd2) begin n_bad++; $display("FAIL clip_drop: got %0d required 2", drop_cnt); end
        n_cmp++; if (wr_total !== w0) begin n_bad++; $display("FAIL clip_nowrite: writes %0d required 0", wr_total - w0); end
        push_pix(H - 1, V - 1, 8'h23);
        pix_valid = 1'b0;
        for (int t = 0; t < 20 && wr_total < w0 + 1; t++) @(negedge clk);
        n_cmp++;
        if (act_q.size() == 0 || act_q[act_q.size()-1] !== {AW'(NPIX - 1), 8'h23}) begin
            n_bad++; $display("FAIL clip_corner: write count %0d, required last write addr %0d data 23", wr_total - w0, NPIX - 1);
        end
        $display("clip: drop_cnt=%0d", drop_cnt);
    endtask

    task automatic test_dedup();
        int w0;
        w0 = wr_total;
        repeat (3) push_pix(5, 5, 8'h11);
        push_pix(6, 5, 8'h11);
        pix_valid = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++; if (wr_total - w0 !== 2) begin n_bad++; $display("FAIL dedup_count: got %0d writes required 2", wr_total - w0); end
        n_cmp++;
        if (act_q.size() < 2 || act_q[act_q.size()-2] !== {19'd3205, 8'h11} || act_q[act_q.size()-1] !== {19'd3206, 8'h11}) begin
            n_bad++; $display("FAIL dedup_addr: last two writes wrong, required 3205 then 3206");
        end
        $display("dedup: %0d writes for 4 pixels", wr_total - w0);
    endtask

    task automatic test_backpressure();
        int idx, w0;
        bit rdy;
        w0 = wr_total;
        wait_mode = 1;
        idx = 0;
        pix_x = 10'd1; pix_y = 9'd3; pix_color = 8'h40; pix_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rdy = pix_ready;
            @(negedge clk);
            if (rdy && pix_valid) begin
                idx++;
                if (idx < 12) begin
                    pix_x = 10'(idx + 1); pix_color = 8'(8'h40 + idx);
                end else begin
                    pix_valid = 1'b0;
                end
            end
            if (i >= 2) begin
                n_cmp++;
                if (fb_we !== 1'b1 || fb_addr !== 19'd1921 || fb_data !== 8'h40) begin
                    n_bad++; $display("FAIL bp_hold: we/addr/data=%b/%0d/%h required 1/1921/40", fb_we, fb_addr, fb_data);
                end
            end
        end
        n_cmp++; if (idx !== 9) begin n_bad++; $display("FAIL bp_accepted: got %0d required 9", idx); end
        n_cmp++; if (pix_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_low: got %b required 0", pix_ready); end
        pix_valid = 1'b0;
        wait_mode = 0;
        for (int t = 0; t < 200 && wr_total < exp_total; t++) @(negedge clk);
        @(negedge clk);
        n_cmp++; if (wr_total - w0 !== 9) begin n_bad++; $display("FAIL bp_written: got %0d required 9", wr_total - w0); end
        n_cmp++; if (pix_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_back: got %b required 1", pix_ready); end
        $display("backpressure: accepted %0d, written %0d", idx, wr_total - w0);
    endtask

    task automatic test_random();
        int x, y, c;
        x = 0; y = 0; c = 0;
        wait_mode = 2;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(3) == 0) begin
                pix_valid = 1'b0;
                @(negedge clk);
            end
            if (i == 0 || $urandom_range(2) != 0) begin
                x = $urandom_range(H + 40);
                y = $urandom_range(V + 3);
                c = $urandom_range(3);
            end
            push_pix(x, y, c);
        end
        pix_valid = 1'b0;
        wait_mode = 0;
        for (int t = 0; t < 2000 && wr_total < exp_total; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_cmp++; if (wr_total !== exp_total) begin n_bad++; $display("FAIL rand_count: writes %0d required %0d", wr_total, exp_total); end
        n_cmp++; if (drop_cnt !== 16'(m_drop)) begin n_bad++; $display("FAIL rand_drop: got %0d required %0d", drop_cnt, m_drop); end
        $display("random: writes %0d drops %0d", wr_total, drop_cnt);
    endtask

    task automatic test_clear();
        int cyc;
        wait_mode = 1;
        @(negedge clk);
        push_pix(3, 4, 8'h55);
        push_pix(7, 4, 8'h66);
        // Push coinciding with the clear request
        n_cmp++; if (pix_ready !== 1'b1) begin n_bad++; $display("FAIL clr_ready_pre: got %b required 1", pix_ready); end
        pix_x = 10'd8; pix_y = 9'd4; pix_color = 8'h77; pix_valid = 1'b1;
        clear_req = 1'b1; clear_color = 8'h00;
        @(negedge clk);
        clear_req = 1'b0; pix_valid = 1'b0; clear_color = 8'hAA;
        wait_mode = 2;
        cyc = 0;
        while (wr_total < clear_end && cyc < 4 * NPIX) begin
            n_cmp++;
            if (busy !== 1'b1 || pix_ready !== 1'b0) begin
                n_bad++; $display("FAIL clr_busy: busy/ready=%b/%b required 1/0 at write %0d", busy, pix_ready, wr_total);
            end
            if (cyc == 100) clear_req = 1'b1;   // ignored while busy
            if (cyc == 101) clear_req = 1'b0;
            @(negedge clk);
            cyc++;
        end
        clear_req = 1'b0;
        wait_mode = 0;
        n_cmp++; if (wr_total !== clear_end) begin n_bad++; $display("FAIL clr_done: writes %0d required %0d", wr_total, clear_end); end
        n_cmp++; if (busy !== 1'b0 || pix_ready !== 1'b1) begin n_bad++; $display("FAIL clr_exit: busy/ready=%b/%b required 0/1", busy, pix_ready); end
        push_pix(8, 4, 8'h77);
        pix_valid = 1'b0;
        for (int t = 0; t < 20 && wr_total < exp_total; t++) @(negedge clk);
        n_cmp++;
        if (act_q.size() == 0 || act_q[act_q.size()-1] !== {19'd2568, 8'h77}) begin
            n_bad++; $display("FAIL clr_tag: old pixel not rewritten, writes %0d required %0d", wr_total, clear_end + 1);
        end
        $display("clear: sweep took %0d cycles", cyc);
    endtask

    task automatic test_scoreboard();
        wr_t a, e;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (act_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL sb_size: got %0d writes required %0d", act_q.size(), exp_q.size());
        end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (a !== e) begin
                n_bad++; $display("FAIL sb_write: addr/data %0d/%h required %0d/%h", a[AW+CW-1:CW], a[CW-1:0], e[AW+CW-1:CW], e[CW-1:0]);
            end
        end
        $display("scoreboard: %0d writes checked in order", wr_total);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_clip();
        test_dedup();
        test_backpressure();
        test_random();
        test_clear();
        test_scoreboard();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
